// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the accumulation and classification stages.
package conv_acc_pkg;

    localparam int N_CLASS   = 10;
    localparam int CLS_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } state_t;

endpackage

// File: rtl/argmax_cls.sv
// Argmax classifier: latches a frame of signed class scores, scans them one per cycle.
// Optional macro ARGMAX_TOP2_EN adds runner-up index and best-minus-second margin outputs.
module argmax_cls #(
    parameter int N_CLASS = conv_acc_pkg::N_CLASS,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = conv_acc_pkg::CLS_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic [DATA_W-1:0] i_res [N_CLASS],
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [IDX_W-1:0]  o_class,
    output logic [DATA_W-1:0] o_score
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0]  o_class2,
    output logic [DATA_W:0]   o_margin
`endif
);
    import conv_acc_pkg::*;

    state_t                   state_reg;
    state_t                   state_next;
    logic [IDX_W-1:0]         cnt_reg;
    logic [DATA_W-1:0]        buf_reg [N_CLASS];
    logic signed [DATA_W-1:0] best_val_reg;
    logic [IDX_W-1:0]         best_idx_reg;
    logic signed [DATA_W-1:0] cur_val;
    logic                     cur_gt_best;
    logic                     pre_fire;
    logic                     post_fire;

    assign cur_val     = buf_reg[cnt_reg];
    assign cur_gt_best = cur_val > best_val_reg;

    always_comb begin
        state_next   = state_reg;
        o_pre_ready  = 1'b0;
        o_post_valid = 1'b0;
        case (state_reg)
            IDLE: o_pre_ready = 1'b1;
            OUT: begin
                o_post_valid = 1'b1;
                o_pre_ready  = i_post_ready;
            end
            default: ;
        endcase
        pre_fire  = i_pre_valid & o_pre_ready;
        post_fire = o_post_valid & i_post_ready;
        case (state_reg)
            IDLE: if (pre_fire) state_next = SCAN;
            SCAN: if (cnt_reg == IDX_W'(N_CLASS - 1)) state_next = OUT;
            OUT:  if (post_fire) state_next = pre_fire ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            best_val_reg <= '0;
            best_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pre_fire) begin
                best_val_reg <= i_res[0];
                best_idx_reg <= '0;
                cnt_reg      <= IDX_W'(1);
            end else if (state_reg == SCAN) begin
                cnt_reg <= cnt_reg + IDX_W'(1);
                // Strictly greater only, so the lowest index keeps a tie.
                if (cur_gt_best) begin
                    best_val_reg <= cur_val;
                    best_idx_reg <= cnt_reg;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CLASS; i++) buf_reg[i] <= '0;
        end else if (pre_fire) begin
            for (int i = 0; i < N_CLASS; i++) buf_reg[i] <= i_res[i];
        end
    end

    assign o_class = best_idx_reg;
    assign o_score = best_val_reg;

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_W-1:0] second_val_reg;
    logic [IDX_W-1:0]         second_idx_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            second_val_reg <= '0;
            second_idx_reg <= '0;
        end else if (pre_fire) begin
            second_val_reg <= i_res[0];
            second_idx_reg <= '0;
        end else if (state_reg == SCAN) begin
            // At index 1 the runner-up is whichever of buf[0]/buf[1] lost.
            if (cur_gt_best) begin
                second_val_reg <= best_val_reg;
                second_idx_reg <= best_idx_reg;
            end else if ((cnt_reg == IDX_W'(1)) || (cur_val > second_val_reg)) begin
                second_val_reg <= cur_val;
                second_idx_reg <= cnt_reg;
            end
        end
    end

    assign o_class2 = second_idx_reg;
    assign o_margin = {best_val_reg[DATA_W-1], best_val_reg}
                    - {second_val_reg[DATA_W-1], second_val_reg};
`endif

endmodule

// File: tb/tb_argmax_cls.sv
// Directed bench for argmax_cls: vector table plus backpressure, reset and streaming sequences.
module tb_argmax_cls;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [31:0] res [10];
    logic        o_post_valid;
    logic        i_post_ready;
    logic [3:0]  o_class;
    logic [31:0] o_score;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]  o_class2;
    logic [32:0] o_margin;
`endif

    argmax_cls dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pre_valid (i_pre_valid),
        .o_pre_ready (o_pre_ready),
        .i_res       (res),
        .o_post_valid(o_post_valid),
        .i_post_ready(i_post_ready),
        .o_class     (o_class),
        .o_score     (o_score)
`ifdef ARGMAX_TOP2_EN
        ,
        .o_class2    (o_class2),
        .o_margin    (o_margin)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [9:0][31:0] sc;
        logic [3:0]       cls;
        logic [31:0]      score;
        logic [3:0]       cls2;
        logic [32:0]      margin;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] fill, input logic [3:0] cls,
                                input logic [31:0] score, input logic [3:0] cls2,
                                input logic [32:0] margin);
        vec_t v;
        for (int i = 0; i < 10; i++) v.sc[i] = fill;
        v.cls = cls; v.score = score; v.cls2 = cls2; v.margin = margin;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 10; i++) res[i] = v.sc[i];
    endtask

    task automatic scramble();
        for (int i = 0; i < 10; i++) res[i] = 32'hDEAD_0000 | 32'(i);
    endtask

    // Starts and ends just after a rising edge; returns with the frame accepted.
    task automatic send(input vec_t v);
        int n = 0;
        load(v);
        i_pre_valid = 1'b1;
        #1;
        while (!o_pre_ready && n < 50) begin
            @(posedge i_clk); #1; n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge i_clk); #1;
        i_pre_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!o_post_valid && cyc < 50) begin
            @(posedge i_clk); #1; cyc++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_class"}, 64'(o_class), 64'(v.cls));
        check({tag, "_score"}, 64'(o_score), 64'(v.score));
`ifdef ARGMAX_TOP2_EN
        check({tag, "_class2"}, 64'(o_class2), 64'(v.cls2));
        check({tag, "_margin"}, 64'(o_margin), 64'(v.margin));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s0 [10] = '{5, -3, 7, 2, 0, 1, 1, 9, -8, 4};
        int cyc;
        int fidx, nres, last_t;
        vec_t v;

        vecs[0] = mk(32'd0, 4'd7, 32'd9, 4'd2, 33'd2);
        for (int i = 0; i < 10; i++) vecs[0].sc[i] = 32'(s0[i]);
        vecs[1] = mk(-32'sd100, 4'd3, -32'sd99, 4'd0, 33'd1);
        vecs[1].sc[3] = -32'sd99;
        vecs[2] = mk(32'd42, 4'd0, 32'd42, 4'd1, 33'd0);
        vecs[3] = mk(32'd0, 4'd9, 32'd1000, 4'd0, 33'd1000);
        vecs[3].sc[9] = 32'd1000;
        vecs[4] = mk(32'd0, 4'd0, -32'sd1, 4'd1, 33'd1);
        for (int i = 0; i < 10; i++) vecs[4].sc[i] = -32'(i + 1);
        vecs[5] = mk(32'h8000_0000, 4'd5, 32'h7FFF_FFFF, 4'd0, 33'h0_FFFF_FFFF);
        vecs[5].sc[5] = 32'h7FFF_FFFF;
        vecs[6] = mk(32'd1, 4'd4, 32'd50, 4'd8, 33'd0);
        vecs[6].sc[4] = 32'd50;
        vecs[6].sc[8] = 32'd50;
        vecs[7] = mk(32'd0, 4'd1, 32'd30, 4'd3, 33'd0);
        vecs[7].sc[0] = 32'd10; vecs[7].sc[1] = 32'd30;
        vecs[7].sc[2] = 32'd20; vecs[7].sc[3] = 32'd30;

        // Reset state
        i_rst = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b1; scramble();
        #12;
        check("rst_post_valid", 64'(o_post_valid), 64'd0);
        check("rst_pre_ready", 64'(o_pre_ready), 64'd1);
        check("rst_class", 64'(o_class), 64'd0);
        check("rst_score", 64'(o_score), 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Vector table, consumer always ready
        for (int k = 0; k < 8; k++) begin
            send(vecs[k]);
            wait_valid(cyc);
            check("latency", 64'(cyc), 64'd9);
            check_result("vec", vecs[k]);
            $display("vec %0d: class=%0d score=%0h cycles=%0d", k, o_class, o_score, cyc);
            @(posedge i_clk); #1;
        end

        // Backpressure: outputs hold, pending frame accepted in the post_fire cycle
        i_post_ready = 1'b0;
        send(vecs[0]);
        wait_valid(cyc);
        check("bp_latency", 64'(cyc), 64'd9);
        for (int k = 0; k < 5; k++) begin
            check_result("bp_hold", vecs[0]);
            check("bp_pre_ready", 64'(o_pre_ready), 64'd0);
            check("bp_post_valid", 64'(o_post_valid), 64'd1);
            if (k == 2) begin
                load(vecs[1]);
                i_pre_valid = 1'b1;
            end
            @(posedge i_clk); #1;
        end
        i_post_ready = 1'b1;
        #1;
        check("bp_pre_ready_rise", 64'(o_pre_ready), 64'd1);
        @(posedge i_clk); #1;
        i_pre_valid = 1'b0;
        scramble();
        check("bp_no_bubble", 64'(o_post_valid), 64'd0);
        wait_valid(cyc);
        check("bp_next_latency", 64'(cyc), 64'd9);
        check_result("bp_next", vecs[1]);
        $display("backpressure: class=%0d score=%0h cycles=%0d", o_class, o_score, cyc);
        @(posedge i_clk); #1;

        // Asynchronous reset mid-SCAN
        send(vecs[2]);
        repeat (3) @(posedge i_clk);
        #3;
        check("scan_pre_ready_before", 64'(o_pre_ready), 64'd0);
        i_rst = 1'b1;
        #1;
        check("scan_rst_post_valid", 64'(o_post_valid), 64'd0);
        check("scan_rst_pre_ready", 64'(o_pre_ready), 64'd1);
        check("scan_rst_class", 64'(o_class), 64'd0);
        #2;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        send(vecs[3]);
        wait_valid(cyc);
        check("after_rst_latency", 64'(cyc), 64'd9);
        check_result("after_rst", vecs[3]);
        $display("reset mid-scan: class=%0d score=%0h", o_class, o_score);

        // Asynchronous reset mid-OUT while stalled
        i_post_ready = 1'b0;
        @(posedge i_clk); #3;
        check("out_valid_before", 64'(o_post_valid), 64'd1);
        i_rst = 1'b1;
        #1;
        check("out_rst_post_valid", 64'(o_post_valid), 64'd0);
        check("out_rst_pre_ready", 64'(o_pre_ready), 64'd1);
        #2;
        i_rst = 1'b0;
        i_post_ready = 1'b1;
        @(posedge i_clk); #1;

        // Back-to-back frames at full rate
        fidx = 0; nres = 0; last_t = 0;
        for (int c = 0; c < 80; c++) begin
            if (fidx < 4) begin
                v = mk(-32'sd5, 4'(2 * fidx + 1), 32'(100 + fidx), 4'd0, 33'd0);
                v.sc[2 * fidx + 1] = 32'(100 + fidx);
                load(v);
                i_pre_valid = 1'b1;
            end else begin
                i_pre_valid = 1'b0;
                scramble();
            end
            @(negedge i_clk);
            if (o_post_valid && i_post_ready) begin
                check("b2b_class", 64'(o_class), 64'(2 * nres + 1));
                check("b2b_score", 64'(o_score), 64'(100 + nres));
                if (nres > 0) check("b2b_spacing", 64'(c - last_t), 64'd10);
                $display("stream result %0d: class=%0d score=%0h cycle=%0d", nres, o_class, o_score, c);
                last_t = c;
                nres++;
            end
            if (i_pre_valid && o_pre_ready) fidx++;
            @(posedge i_clk); #1;
        end
        check("b2b_frames_sent", 64'(fidx), 64'd4);
        check("b2b_results", 64'(nres), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
